// File: rtl/operand_issue_fifo.sv
// Operand-pair FIFO feeding a registered adder: buffers valid/ready pushes and
// issues one pair per start pulse, with a programmable idle gap, stall and flush.
module operand_issue_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     start,
  output logic [W-1:0]             a,
  output logic [W-1:0]             b,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  typedef enum logic {IDLE, GAPS} state_t;

  pair_t          mem [DEPTH];
  pair_t          head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [GW-1:0]  gap_cnt;
  state_t         state;
  logic           full, empty, push, pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign head     = mem[rd_ptr];
  // flush wins over both sides; a full FIFO refuses a push even if it pops
  assign push     = in_valid && !full && !flush;
  assign pop      = (state == IDLE) && !empty && !stall && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      gap_cnt    <= '0;
      start      <= 1'b0;
      a          <= '0;
      b          <= '0;
      issued_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= IDLE;
      gap_cnt <= '0;
      start   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        IDLE: begin
          start <= pop;
          if (pop) begin
            a          <= head.a;
            b          <= head.b;
            issued_cnt <= issued_cnt + 16'd1;
            if (GAP > 0) begin
              state   <= GAPS;
              gap_cnt <= GW'(GAP);
            end
          end
        end
        GAPS: begin
          // stall does not hold the gap countdown
          start <= 1'b0;
          if (gap_cnt <= GW'(1)) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_issue_fifo.sv
// Bench for operand_issue_fifo: a GAP=1 and a GAP=0 instance share stimulus and
// are checked against queue-based models of the issue/spacing rules.
module tb_operand_issue_fifo;
  localparam int W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;

  logic in_ready0, start0, in_ready1, start1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0] count0, count1;
  logic [15:0] issued0, issued1;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  operand_issue_fifo #(.W(W), .DEPTH(DEPTH), .GAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .stall(stall), .flush(flush), .start(start0),
    .a(a0), .b(b0), .count(count0), .issued_cnt(issued0));

  operand_issue_fifo #(.W(W), .DEPTH(DEPTH), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .stall(stall), .flush(flush), .start(start1),
    .a(a1), .b(b1), .count(count1), .issued_cnt(issued1));

  // Reference: a queue plus "earliest edge allowed to issue" bookkeeping.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int G = (g == 0) ? 1 : 0;
    logic [31:0] q[$];
    logic st;
    logic [15:0] ma, mb, ic;
    int en, nok;

    task automatic mreset();
      q.delete(); st = 0; ma = 0; mb = 0; ic = 0; en = 0; nok = 0;
    endtask

    task automatic step();
      logic [31:0] hd;
      bit was_full;
      en++;
      if (flush) begin
        q.delete(); st = 0; nok = 0;
      end else begin
        was_full = (q.size() == DEPTH);
        st = 0;
        if (q.size() > 0 && !stall && en >= nok) begin
          hd = q.pop_front();
          ma = hd[31:16]; mb = hd[15:0]; st = 1; ic++; nok = en + 1 + G;
        end
        if (in_valid && !was_full) q.push_back({in_a, in_b});
      end
    endtask

    always @(posedge clk or negedge rst_n)
      if (!rst_n) mreset(); else step();
  end

  task automatic do_flush();
    flush = 1; in_valid = 0;
    @(negedge clk);
    flush = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nvec++;
    if (start0 !== 0 || a0 !== 0 || b0 !== 0 || count0 !== 0 || in_ready0 !== 1 || issued0 !== 0) begin
      nerr++;
      $display("FAIL reset_u0: start=%b a=%h b=%h count=%0d ready=%b issued=%0d, want 0 0 0 0 1 0",
               start0, a0, b0, count0, in_ready0, issued0);
    end
    nvec++;
    if (start1 !== 0 || count1 !== 0 || in_ready1 !== 1 || issued1 !== 0) begin
      nerr++;
      $display("FAIL reset_u1: start=%b count=%0d ready=%b issued=%0d", start1, count1, in_ready1, issued1);
    end
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      nvec++;
      if (start0 !== 0 || start1 !== 0) begin
        nerr++; $display("FAIL reset_idle: start0=%b start1=%b, want 0", start0, start1);
      end
    end
  endtask

  task automatic test_single();
    in_valid = 1; in_a = 16'h3; in_b = 16'h4;
    @(negedge clk);
    in_valid = 0;
    nvec++;
    if (count0 !== 1 || start0 !== 0) begin
      nerr++; $display("FAIL single_push: count=%0d start=%b, want 1 0", count0, start0);
    end
    @(negedge clk);
    nvec++;
    if (start0 !== 1 || a0 !== 16'h3 || b0 !== 16'h4 || issued0 !== 1 || count0 !== 0) begin
      nerr++;
      $display("FAIL single_issue: start=%b a=%h b=%h issued=%0d count=%0d, want 1 3 4 1 0",
               start0, a0, b0, issued0, count0);
    end
    @(negedge clk);
    nvec++;
    if (start0 !== 0 || a0 !== 16'h3 || b0 !== 16'h4) begin
      nerr++; $display("FAIL single_pulse: start=%b a=%h b=%h, want 0 3 4", start0, a0, b0);
    end
  endtask

  task automatic test_fill();
    int got = 0, last = 0, t = 0;
    bit pend;
    do_flush();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_a = 16'h10 + 16'(i); in_b = 16'h20 + 16'(i);
      @(negedge clk);
    end
    in_a = 16'h14; in_b = 16'h24;
    @(negedge clk);
    nvec++;
    if (in_ready0 !== 0 || count0 !== 4) begin
      nerr++; $display("FAIL fill_full: ready=%b count=%0d, want 0 4", in_ready0, count0);
    end
    stall = 0;
    while (got < 5 && t < 60) begin
      pend = in_valid && in_ready0;
      @(negedge clk); t++;
      if (pend) in_valid = 0;
      if (start0) begin
        nvec++;
        if (a0 !== 16'h10 + 16'(got) || b0 !== 16'h20 + 16'(got) || (got > 0 && t - last != 2)) begin
          nerr++;
          $display("FAIL fill_order: #%0d a=%h b=%h gap=%0d, want a=%h gap=2",
                   got, a0, b0, t - last, 16'h10 + 16'(got));
        end
        last = t; got++;
      end
    end
    nvec++;
    if (got != 5) begin
      nerr++; $display("FAIL fill_count: issued %0d, want 5", got);
    end
    in_valid = 0;
  endtask

  task automatic test_gap0_burst();
    do_flush();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = 16'h30 + 16'(i); in_b = 16'h40 + 16'(i);
      @(negedge clk);
    end
    in_valid = 0; stall = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (start1 !== 1 || a1 !== 16'h30 + 16'(i) || b1 !== 16'h40 + 16'(i)) begin
        nerr++;
        $display("FAIL burst_%0d: start=%b a=%h b=%h, want 1 %h %h",
                 i, start1, a1, b1, 16'h30 + 16'(i), 16'h40 + 16'(i));
      end
    end
    @(negedge clk);
    nvec++;
    if (start1 !== 0 || a1 !== 16'h32) begin
      nerr++; $display("FAIL burst_end: start=%b a=%h, want 0 0032", start1, a1);
    end
  endtask

  task automatic test_flush_wrap();
    int sent = 0, got = 0, t = 0;
    bit pend;
    do_flush();
    repeat (3) @(negedge clk);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = 16'h50 + 16'(i); in_b = 16'h58 + 16'(i);
      @(negedge clk);
    end
    nvec++;
    if (count0 !== 3) begin
      nerr++; $display("FAIL flush_pre: count=%0d, want 3", count0);
    end
    in_a = 16'h5F; in_b = 16'h5E; flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0; stall = 0;
    nvec++;
    if (count0 !== 0 || start0 !== 0 || count1 !== 0 || in_ready0 !== 1) begin
      nerr++;
      $display("FAIL flush_clear: count0=%0d start0=%b count1=%0d ready=%b, want 0 0 0 1",
               count0, start0, count1, in_ready0);
    end
    repeat (3) begin
      @(negedge clk);
      nvec++;
      if (start0 !== 0 || start1 !== 0) begin
        nerr++; $display("FAIL flush_drop: start0=%b start1=%b, want 0", start0, start1);
      end
    end
    in_valid = 1; in_a = 16'h60; in_b = 16'h70;
    while (got < 10 && t < 100) begin
      pend = in_valid && in_ready0;
      @(negedge clk); t++;
      if (start0) begin
        nvec++;
        if (a0 !== 16'h60 + 16'(got) || b0 !== 16'h70 + 16'(got)) begin
          nerr++;
          $display("FAIL wrap_order: #%0d a=%h b=%h, want %h %h",
                   got, a0, b0, 16'h60 + 16'(got), 16'h70 + 16'(got));
        end
        got++;
      end
      if (pend) begin
        sent++;
        if (sent < 10) begin in_a = 16'h60 + 16'(sent); in_b = 16'h70 + 16'(sent); end
        else in_valid = 0;
      end
    end
    nvec++;
    if (got != 10 || count0 !== 0) begin
      nerr++; $display("FAIL wrap_count: issued %0d count=%0d, want 10 0", got, count0);
    end
    in_valid = 0;
  endtask

  task automatic test_async_reset();
    int t = 0;
    do_flush();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = 16'h80 + 16'(i); in_b = 16'h90 + 16'(i);
      @(negedge clk);
    end
    in_valid = 0; stall = 0;
    do begin @(negedge clk); t++; end while (!start0 && t < 10);
    nvec++;
    if (start0 !== 1 || count0 !== 2) begin
      nerr++; $display("FAIL areset_pre: start=%b count=%0d, want 1 2", start0, count0);
    end
    #2 rst_n = 0;
    #1;
    nvec++;
    if (start0 !== 0 || a0 !== 0 || b0 !== 0 || count0 !== 0 || issued0 !== 0 || in_ready0 !== 1) begin
      nerr++;
      $display("FAIL areset_now: start=%b a=%h b=%h count=%0d issued=%0d ready=%b, want 0 0 0 0 0 1",
               start0, a0, b0, count0, issued0, in_ready0);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      nvec++;
      if (start0 !== 0 || start1 !== 0 || count0 !== 0) begin
        nerr++; $display("FAIL areset_after: start0=%b start1=%b count0=%0d, want 0 0 0", start0, start1, count0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      nvec++;
      if (start0 !== mdl[0].st || a0 !== mdl[0].ma || b0 !== mdl[0].mb || issued0 !== mdl[0].ic ||
          count0 !== 3'(mdl[0].q.size()) || in_ready0 !== (mdl[0].q.size() < DEPTH)) begin
        nerr++;
        $display("FAIL rand_u0 cyc %0d: start=%b a=%h b=%h cnt=%0d iss=%0d, want %b %h %h %0d %0d",
                 c, start0, a0, b0, count0, issued0, mdl[0].st, mdl[0].ma, mdl[0].mb,
                 mdl[0].q.size(), mdl[0].ic);
      end
      nvec++;
      if (start1 !== mdl[1].st || a1 !== mdl[1].ma || b1 !== mdl[1].mb || issued1 !== mdl[1].ic ||
          count1 !== 3'(mdl[1].q.size()) || in_ready1 !== (mdl[1].q.size() < DEPTH)) begin
        nerr++;
        $display("FAIL rand_u1 cyc %0d: start=%b a=%h b=%h cnt=%0d iss=%0d, want %b %h %h %0d %0d",
                 c, start1, a1, b1, count1, issued1, mdl[1].st, mdl[1].ma, mdl[1].mb,
                 mdl[1].q.size(), mdl[1].ic);
      end
      in_valid = ($urandom % 4) != 0;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      stall    = ($urandom % 5) == 0;
      flush    = ($urandom % 29) == 0;
    end
    in_valid = 0; stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_gap0_burst();
    test_flush_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
